// File: rtl/imem_loader_if.sv
// Loader-side bus: byte-stream handshake, IMEM write port and load status.
// master = loader (imem_loader), slave = byte source / IMEM / status observer.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              LD_start;
    logic              LD_byte_valid;
    logic [7:0]        LD_byte;
    logic              LD_byte_ready;
    logic              IMEM_wr_en;
    logic [ADDR_W-1:0] IMEM_wr_addr;
    logic [31:0]       IMEM_wr_data;
    logic              CPU_hold;
    logic              LD_done;
    logic              LD_err;
    logic [7:0]        LD_words;

    modport master (
        input  LD_start, LD_byte_valid, LD_byte,
        output LD_byte_ready, IMEM_wr_en, IMEM_wr_addr, IMEM_wr_data,
               CPU_hold, LD_done, LD_err, LD_words
    );

    modport slave (
        output LD_start, LD_byte_valid, LD_byte,
        input  LD_byte_ready, IMEM_wr_en, IMEM_wr_addr, IMEM_wr_data,
               CPU_hold, LD_done, LD_err, LD_words
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: count byte N, then 4*N big-endian data bytes written as words.
// Optional trailing XOR checksum byte when LOADER_CHECKSUM_EN is defined.
//
// state   | meaning
// IDLE    | waiting for LD_start after reset
// COUNT   | accepting the word-count byte
// DATA    | accepting data bytes into the word shifter
// WRITE   | one-cycle IMEM write strobe
// CHECK   | accepting the checksum byte (LOADER_CHECKSUM_EN only)
// DONE    | image loaded, CPU released
// ERROR   | image rejected, CPU held
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic         SYS_clk,
    input  logic         SYS_reset_n,
    imem_loader_if.master ld
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_COUNT = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd6;
`endif
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    logic [2:0]        state_q, state_d;
    logic [7:0]        n_q, n_d;
    logic [23:0]       shift_q, shift_d;
    logic [1:0]        bcnt_q, bcnt_d;
    logic [7:0]        idx_q, idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [7:0]        words_q, words_d;
    logic              ready;
    logic              accept;
    logic              last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
    assign ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
`else
    assign ready = (state_q == S_COUNT) || (state_q == S_DATA);
`endif

    assign accept    = ready && ld.LD_byte_valid;
    assign last_word = (idx_q == n_q - 8'd1);

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        shift_d = shift_q;
        bcnt_d  = bcnt_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        words_d = words_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (ld.LD_start) begin
                    state_d = S_COUNT;
                    words_d = 8'd0;
                    bcnt_d  = 2'd0;
                    idx_d   = 8'd0;
                end
            end
            S_COUNT: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = ld.LD_byte;
`endif
                    if ((ld.LD_byte == 8'd0) || ({1'b0, ld.LD_byte} > DEPTH_L)) begin
                        state_d = S_ERROR;
                    end else begin
                        n_d     = ld.LD_byte;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ ld.LD_byte;
`endif
                    shift_d = {shift_q[15:0], ld.LD_byte};
                    bcnt_d  = bcnt_q + 2'd1;
                    // Word and address are registered here so they are stable for the whole WRITE cycle.
                    if (bcnt_q == 2'd3) begin
                        data_d  = {shift_q, ld.LD_byte};
                        addr_d  = ADDR_W'({idx_q, 2'b00});
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                words_d = words_q + 8'd1;
                if (last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    idx_d   = idx_q + 8'd1;
                    state_d = S_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    state_d = (ld.LD_byte == csum_q) ? S_DONE : S_ERROR;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge SYS_clk or negedge SYS_reset_n) begin
        if (!SYS_reset_n) begin
            state_q <= S_IDLE;
            n_q     <= 8'd0;
            shift_q <= 24'd0;
            bcnt_q  <= 2'd0;
            idx_q   <= 8'd0;
            addr_q  <= '0;
            data_q  <= 32'd0;
            words_q <= 8'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            bcnt_q  <= bcnt_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            words_q <= words_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign ld.LD_byte_ready = ready;
    assign ld.IMEM_wr_en    = (state_q == S_WRITE);
    assign ld.IMEM_wr_addr  = addr_q;
    assign ld.IMEM_wr_data  = data_q;
    assign ld.CPU_hold      = (state_q != S_DONE);
    assign ld.LD_done       = (state_q == S_DONE);
    assign ld.LD_err        = (state_q == S_ERROR);
    assign ld.LD_words      = words_q;
endmodule
